// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and display geometry for the Pong pipeline.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

endpackage

// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD counter, clear over increment, 99 wraps to 00.
module bcd_counter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
            if (ones == 4'd9)
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame tick, game FSM, lives, score and freeze control for Pong.
module pong_game_ctrl #(
    parameter int LIVES          = 3,
    parameter int RESTART_FRAMES = 120,
    parameter int H_DISPLAY      = pong_pkg::H_DISPLAY,
    parameter int V_DISPLAY      = pong_pkg::V_DISPLAY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn,
    input  logic       hit,
    input  logic       miss,
    output logic       frame_tick,
    output logic       gra_still,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones
);

    import pong_pkg::*;

    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("LIVES must be 1..3");
    end
    if (RESTART_FRAMES < 1 || RESTART_FRAMES > 255) begin : g_bad_restart
        $error("RESTART_FRAMES must be 1..255");
    end
    if (H_DISPLAY < 1 || H_DISPLAY > 1023 || V_DISPLAY < 1 || V_DISPLAY > 1023) begin : g_bad_geom
        $error("display size must fit the 10-bit pixel counters");
    end

    state_t     state_q, state_n;
    logic [1:0] lives_n;
    logic [7:0] timer;
    logic       btn_prev, btn_rise, timer_up, frame_qual, load, clr, inc;

    assign frame_qual = p_tick && x == 10'd0 && y == 10'(V_DISPLAY);
    assign btn_rise   = btn & ~btn_prev;
    assign timer_up   = timer == 8'd0;
    assign state      = state_q;

    always_comb begin
        state_n = state_q;
        lives_n = lives;
        load    = 1'b0;
        clr     = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_NEWGAME: if (btn_rise) begin
                state_n = ST_PLAY;
                lives_n = 2'(LIVES);
                clr     = 1'b1;
            end
            ST_PLAY: if (miss) begin
                state_n = (lives == 2'd1) ? ST_OVER : ST_NEWBALL;
                lives_n = lives - 2'd1;
                load    = 1'b1;
            end else
                inc = hit;
            ST_NEWBALL: state_n = (timer_up && btn_rise) ? ST_PLAY : ST_NEWBALL;
            ST_OVER:    state_n = timer_up ? ST_NEWGAME : ST_OVER;
            default:    state_n = ST_NEWGAME;
        endcase
    end

    // gra_still follows the next state so it switches in the same clk as state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NEWGAME;
            gra_still  <= 1'b1;
            lives      <= 2'(LIVES);
            frame_tick <= 1'b0;
            timer      <= 8'd0;
            btn_prev   <= 1'b1;
        end else begin
            state_q    <= state_n;
            gra_still  <= state_n != ST_PLAY;
            lives      <= lives_n;
            frame_tick <= frame_qual;
            btn_prev   <= btn;
            timer      <= load ? 8'(RESTART_FRAMES) : (frame_tick && !timer_up) ? timer - 8'd1 : timer;
        end
    end

    bcd_counter2 u_score (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .inc  (inc),
        .tens (score_tens),
        .ones (score_ones)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed vector table plus hand sequences for pong_game_ctrl.
module tb_pong_game_ctrl;

    logic       clk = 1'b0, reset = 1'b1, p_tick = 1'b0, btn = 1'b1, hit = 1'b0, miss = 1'b0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic       frame_tick, gra_still;
    logic [1:0] state, lives;
    logic [3:0] score_tens, score_ones;

    int errors = 0, checks = 0;

    typedef struct {
        logic r, b, h, m, f;
        int   st, lv, sc, still, ft;
    } vec_t;
    vec_t tv[$];

    pong_game_ctrl #(.LIVES(3), .RESTART_FRAMES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .x         (x),
        .y         (y),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .frame_tick(frame_tick),
        .gra_still (gra_still),
        .state     (state),
        .lives     (lives),
        .score_tens(score_tens),
        .score_ones(score_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int lv, input int sc, input int still);
        chk({tag, "_state"}, int'(state), st);
        chk({tag, "_lives"}, int'(lives), lv);
        chk({tag, "_score"}, int'({score_tens, score_ones}), sc);
        chk({tag, "_still"}, int'(gra_still), still);
    endtask

    // f drives a qualifying frame position (p_tick at x=0, y=480) for one clk
    task automatic step(input logic r, input logic b, input logic h, input logic m, input logic f);
        @(negedge clk);
        reset  = r;
        btn    = b;
        hit    = h;
        miss   = m;
        p_tick = f;
        x      = 10'd0;
        y      = f ? 10'd480 : 10'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic b, input logic h, input logic m, input logic f,
                       input int st, input int lv, input int sc, input int still, input int ft);
        vec_t v;
        v = '{r, b, h, m, f, st, lv, sc, still, ft};
        tv.push_back(v);
    endtask

    initial begin
        int ft_cnt, bad, exp_sc;
        logic q;
        //   r  b  h  m  f   st lv score  still ft
        add(1, 1, 0, 0, 0,  0, 3, 'h00, 1, 0);
        add(0, 1, 0, 0, 0,  0, 3, 'h00, 1, 0);
        add(0, 0, 1, 1, 0,  0, 3, 'h00, 1, 0);
        add(0, 1, 0, 0, 0,  1, 3, 'h00, 0, 0);
        add(0, 1, 1, 0, 0,  1, 3, 'h01, 0, 0);
        add(0, 0, 1, 0, 0,  1, 3, 'h02, 0, 0);
        add(0, 1, 0, 0, 0,  1, 3, 'h02, 0, 0);
        add(0, 0, 1, 1, 0,  2, 2, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 2, 'h02, 1, 1);
        add(0, 1, 0, 0, 0,  2, 2, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 2, 'h02, 1, 1);
        add(0, 0, 0, 0, 0,  2, 2, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 2, 'h02, 1, 1);
        add(0, 1, 0, 0, 0,  2, 2, 'h02, 1, 0);
        add(0, 1, 0, 0, 0,  2, 2, 'h02, 1, 0);
        add(0, 0, 0, 0, 0,  2, 2, 'h02, 1, 0);
        add(0, 1, 0, 0, 0,  1, 2, 'h02, 0, 0);
        add(0, 0, 0, 1, 0,  2, 1, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 'h02, 1, 1);
        add(0, 0, 0, 0, 0,  2, 1, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 'h02, 1, 1);
        add(0, 0, 0, 0, 0,  2, 1, 'h02, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 'h02, 1, 1);
        add(0, 0, 0, 0, 0,  2, 1, 'h02, 1, 0);
        add(0, 1, 0, 0, 0,  1, 1, 'h02, 0, 0);
        add(0, 0, 1, 0, 0,  1, 1, 'h03, 0, 0);
        add(0, 0, 0, 1, 0,  3, 0, 'h03, 1, 0);
        add(0, 1, 0, 0, 1,  3, 0, 'h03, 1, 1);
        add(0, 0, 1, 0, 0,  3, 0, 'h03, 1, 0);
        add(0, 0, 0, 0, 1,  3, 0, 'h03, 1, 1);
        add(0, 0, 0, 1, 0,  3, 0, 'h03, 1, 0);
        add(0, 0, 0, 0, 1,  3, 0, 'h03, 1, 1);
        add(0, 0, 0, 0, 0,  3, 0, 'h03, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 'h03, 1, 0);
        add(0, 0, 1, 1, 0,  0, 0, 'h03, 1, 0);
        add(0, 1, 0, 0, 0,  1, 3, 'h00, 0, 0);

        foreach (tv[i]) begin
            step(tv[i].r, tv[i].b, tv[i].h, tv[i].m, tv[i].f);
            chk_all($sformatf("v%0d", i), tv[i].st, tv[i].lv, tv[i].sc, tv[i].still);
            chk($sformatf("v%0d_ft", i), int'(frame_tick), tv[i].ft);
        end

        // 100 back-to-back hits: crosses 09->10 and wraps 99->00
        for (int n = 1; n <= 100; n++) begin
            step(0, 0, 1, 0, 0);
            exp_sc = ((n % 100) / 10) * 16 + (n % 10);
            chk($sformatf("hit%0d_score", n), int'({score_tens, score_ones}), exp_sc);
        end
        chk("hits_state", int'(state), 1);

        // scan rows 478..482 with p_tick every other clk: one tick, only after x=0,y=480
        step(0, 0, 0, 0, 0);
        ft_cnt = 0;
        bad    = 0;
        for (int yy = 478; yy <= 482; yy++)
            for (int xx = 0; xx < 800; xx++)
                for (int ph = 0; ph < 2; ph++) begin
                    @(negedge clk);
                    x      = 10'(xx);
                    y      = 10'(yy);
                    p_tick = (ph == 0);
                    q      = (ph == 0) && xx == 0 && yy == 480;
                    @(posedge clk);
                    #1;
                    if (frame_tick !== q) bad++;
                    if (frame_tick) ft_cnt++;
                end
        chk("ft_position", bad, 0);
        chk("ft_count", ft_cnt, 1);

        // reset in NEWBALL with timer=2
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("pre_miss", 1, 3, 'h02, 0);
        step(0, 0, 0, 1, 0);
        chk_all("nb", 2, 2, 'h02, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("rst_async", 0, 3, 'h00, 1);
        chk("rst_async_ft", int'(frame_tick), 0);
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_all("rst_hold", 0, 3, 'h00, 1);
        chk("rst_hold_ft", int'(frame_tick), 0);
        step(0, 0, 0, 0, 0);
        chk_all("rst_rel", 0, 3, 'h00, 1);
        step(0, 1, 0, 0, 0);
        chk_all("restart", 1, 3, 'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
